// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, FSM states and
// the pc_sel / wb_sel / trap_cause codes driven onto the datapath.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5,
      TRAP   = 3'd6
   } state_e;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JALR   = 2'd2;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM    = 2'd2;
   localparam logic [1:0] CAUSE_DMEM    = 2'd3;

   function automatic logic is_exec_op(input logic [6:0] op);
      return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter shared by the instruction-fetch and data-memory handshakes;
// flags a timeout when a request has waited MEM_TIMEOUT cycles without ready.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TIMER_W     = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_cnt_en,
   input  logic i_ready,
   output logic o_timeout
);

   localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MEM_TIMEOUT);

   logic [TIMER_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear || i_ready) begin
         r_cnt <= '0;
      end else if (i_cnt_en && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A ready arriving at the limit wins over the timeout.
   assign o_timeout = i_cnt_en && !i_ready && (r_cnt == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables and owns the memory handshakes with timeout trapping.
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TIMER_W     = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [4:0] rd,
   input  logic       branch_taken,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       ir_we,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       reg_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic [1:0] wb_sel,
   output logic       alu_src_imm,
   output logic       retire,
   output logic       halted,
   output logic       trap,
   output logic [1:0] trap_cause,
   output logic [2:0] state
);

   state_e     r_state;
   logic       r_run;
   logic       r_halted;
   logic       r_trap;
   logic [1:0] r_cause;

   logic w_in_fetch;
   logic w_in_mem;
   logic w_ready;
   logic w_timeout;
   logic w_unused;

   // r_run holds off the first fetch request until one clock after reset release.
   assign w_in_fetch = r_run && (r_state == FETCH);
   assign w_in_mem   = (r_state == MEM);
   assign w_ready    = w_in_fetch ? imem_ready : dmem_ready;
   assign w_unused   = ^funct3;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .TIMER_W    (TIMER_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (!(w_in_fetch || w_in_mem)),
      .i_cnt_en (w_in_fetch || w_in_mem),
      .i_ready  (w_ready),
      .o_timeout(w_timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= FETCH;
         r_run    <= 1'b0;
         r_halted <= 1'b0;
         r_trap   <= 1'b0;
         r_cause  <= CAUSE_NONE;
      end else begin
         r_run <= 1'b1;
         case (r_state)
            FETCH: begin
               if (r_run && imem_ready) begin
                  r_state <= DECODE;
               end else if (w_timeout) begin
                  r_state <= TRAP;
                  r_trap  <= 1'b1;
                  r_cause <= CAUSE_IMEM;
               end
            end
            DECODE: begin
               if (is_exec_op(opcode)) begin
                  r_state <= EXEC;
               end else if (opcode == OP_SYSTEM) begin
                  r_state  <= HALT;
                  r_halted <= 1'b1;
               end else begin
                  r_state <= TRAP;
                  r_trap  <= 1'b1;
                  r_cause <= CAUSE_ILLEGAL;
               end
            end
            EXEC: begin
               if (opcode == OP_LOAD || opcode == OP_STORE) r_state <= MEM;
               else if (opcode == OP_BRANCH)                r_state <= FETCH;
               else                                         r_state <= WB;
            end
            MEM: begin
               if (dmem_ready) begin
                  r_state <= (opcode == OP_STORE) ? FETCH : WB;
               end else if (w_timeout) begin
                  r_state <= TRAP;
                  r_trap  <= 1'b1;
                  r_cause <= CAUSE_DMEM;
               end
            end
            WB:      r_state <= FETCH;
            default: r_state <= r_state;
         endcase
      end
   end

   always_comb begin
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_we      = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = PC_PLUS4;
      wb_sel      = WB_ALU;
      alu_src_imm = 1'b0;
      case (r_state)
         FETCH: begin
            imem_req = r_run;
            ir_we    = r_run && imem_ready;
         end
         EXEC: begin
            alu_src_imm = opcode inside {OP_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_LUI};
            if (opcode == OP_BRANCH) begin
               pc_we  = 1'b1;
               pc_sel = branch_taken ? PC_BRANCH : PC_PLUS4;
            end
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opcode == OP_STORE);
            pc_we    = (opcode == OP_STORE) && dmem_ready;
         end
         WB: begin
            reg_we = (rd != 5'd0);
            pc_we  = 1'b1;
            if (opcode == OP_LOAD)                          wb_sel = WB_MEM;
            else if (opcode == OP_JAL || opcode == OP_JALR) wb_sel = WB_PC4;
            if (opcode == OP_JAL)       pc_sel = PC_BRANCH;
            else if (opcode == OP_JALR) pc_sel = PC_JALR;
         end
         default: ;
      endcase
   end

   assign retire     = pc_we;
   assign halted     = r_halted;
   assign trap       = r_trap;
   assign trap_cause = r_cause;
   assign state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with MEM_TIMEOUT=4: checks every output each
// cycle against hand-computed vectors, including timeouts, traps, halt and mid-access reset.
module tb_multicycle_control;
   import riscv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic       branch_taken, imem_ready, dmem_ready;
   logic       imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, alu_src_imm, retire;
   logic       halted, trap;
   logic [1:0] pc_sel, wb_sel, trap_cause;
   logic [2:0] state;

   int n_vec = 0;
   int n_err = 0;

   multicycle_control #(
      .MEM_TIMEOUT(4),
      .TIMER_W    (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .funct3      (funct3),
      .rd          (rd),
      .branch_taken(branch_taken),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .imem_req    (imem_req),
      .ir_we       (ir_we),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .reg_we      (reg_we),
      .pc_we       (pc_we),
      .pc_sel      (pc_sel),
      .wb_sel      (wb_sel),
      .alu_src_imm (alu_src_imm),
      .retire      (retire),
      .halted      (halted),
      .trap        (trap),
      .trap_cause  (trap_cause),
      .state       (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // retire is expected to equal pc_we in every vector.
   task automatic chk(input string tag, input logic [2:0] st, input logic imem, input logic irwe,
                      input logic dreq, input logic dwe, input logic regwe, input logic pcwe,
                      input logic [1:0] pcsel, input logic [1:0] wbsel, input logic alus,
                      input logic hlt, input logic trp, input logic [1:0] cause);
      logic [18:0] obs, exp;
      obs = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire, pc_sel, wb_sel,
             alu_src_imm, halted, trap, trap_cause, state};
      exp = {imem, irwe, dreq, dwe, regwe, pcwe, pcwe, pcsel, wbsel, alus, hlt, trp, cause, st};
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1 chk("in_reset", 3'd0, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      tick();
      rst_n = 1'b1;
      #1 chk("reset_release", 3'd0, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
   endtask

   task automatic fetch_decode(input string tag, input logic [6:0] op, input logic [4:0] rdv);
      tick();
      opcode     = op;
      rd         = rdv;
      imem_ready = 1'b1;
      #1 chk({tag, "_fetch"}, 3'd0, 1,1,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      tick();
      imem_ready = 1'b0;
      #1 chk({tag, "_decode"}, 3'd1, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
   endtask

   initial begin
      rst_n = 1'b1; opcode = 7'd0; funct3 = 3'd0; rd = 5'd0;
      branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      #2;
      do_reset();

      // ADD x1
      fetch_decode("add", OP_R, 5'd1);
      tick(); #1 chk("add_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      tick(); #1 chk("add_wb",   3'd4, 0,0,0,0,1,1, 2'd0,2'd0, 0,0,0, 2'd0);
      tick(); #1 chk("add_next_fetch", 3'd0, 1,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);

      // LOAD x5, dmem_ready after 3 wait cycles
      fetch_decode("ld", OP_LOAD, 5'd5);
      tick(); #1 chk("ld_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 1,0,0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1 chk("ld_mem_wait", 3'd3, 0,0,1,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      end
      tick(); dmem_ready = 1'b1;
      #1 chk("ld_mem_ready", 3'd3, 0,0,1,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      tick(); dmem_ready = 1'b0;
      #1 chk("ld_wb", 3'd4, 0,0,0,0,1,1, 2'd0,2'd1, 0,0,0, 2'd0);

      // Taken then not-taken branch
      branch_taken = 1'b1;
      fetch_decode("beq_t", OP_BRANCH, 5'd3);
      tick(); #1 chk("beq_t_exec", 3'd2, 0,0,0,0,0,1, 2'd1,2'd0, 0,0,0, 2'd0);
      branch_taken = 1'b0;
      fetch_decode("beq_n", OP_BRANCH, 5'd3);
      tick(); #1 chk("beq_n_exec", 3'd2, 0,0,0,0,0,1, 2'd0,2'd0, 0,0,0, 2'd0);

      // Zero-wait store
      fetch_decode("sw", OP_STORE, 5'd7);
      tick(); #1 chk("sw_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 1,0,0, 2'd0);
      tick(); dmem_ready = 1'b1;
      #1 chk("sw_mem", 3'd3, 0,0,1,1,0,1, 2'd0,2'd0, 0,0,0, 2'd0);
      tick(); dmem_ready = 1'b0;
      #1 chk("sw_next_fetch", 3'd0, 1,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);

      // ADDI x0: no register write but still retires
      fetch_decode("addi0", OP_IMM, 5'd0);
      tick(); #1 chk("addi0_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 1,0,0, 2'd0);
      tick(); #1 chk("addi0_wb",   3'd4, 0,0,0,0,0,1, 2'd0,2'd0, 0,0,0, 2'd0);

      // JAL x1 and JALR x2
      fetch_decode("jal", OP_JAL, 5'd1);
      tick(); #1 chk("jal_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      tick(); #1 chk("jal_wb",   3'd4, 0,0,0,0,1,1, 2'd1,2'd2, 0,0,0, 2'd0);
      fetch_decode("jalr", OP_JALR, 5'd2);
      tick(); #1 chk("jalr_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 1,0,0, 2'd0);
      tick(); #1 chk("jalr_wb",   3'd4, 0,0,0,0,1,1, 2'd2,2'd2, 0,0,0, 2'd0);

      // imem never ready: 5 FETCH cycles then TRAP cause 2
      for (int i = 0; i < 5; i++) begin
         tick(); #1 chk("imem_wait", 3'd0, 1,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      end
      tick(); #1 chk("imem_timeout", 3'd6, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,1, 2'd2);
      tick(); #1 chk("imem_trap_hold", 3'd6, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,1, 2'd2);
      do_reset();

      // Ready arriving exactly at the limit wins; the fetched opcode is illegal
      opcode = 7'b0001111;
      for (int i = 0; i < 4; i++) begin
         tick(); #1 chk("imem_edge_wait", 3'd0, 1,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      end
      tick(); imem_ready = 1'b1;
      #1 chk("imem_edge_ready", 3'd0, 1,1,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      tick(); imem_ready = 1'b0;
      #1 chk("illegal_decode", 3'd1, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      imem_ready = 1'b1; dmem_ready = 1'b1;
      for (int i = 0; i < 21; i++) begin
         tick(); #1 chk("illegal_trap", 3'd6, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,1, 2'd1);
      end
      imem_ready = 1'b0; dmem_ready = 1'b0;
      do_reset();

      // SYSTEM halts
      fetch_decode("ecall", OP_SYSTEM, 5'd0);
      for (int i = 0; i < 3; i++) begin
         tick(); #1 chk("halt", 3'd5, 0,0,0,0,0,0, 2'd0,2'd0, 0,1,0, 2'd0);
      end
      do_reset();

      // dmem never ready: 5 MEM cycles then TRAP cause 3
      fetch_decode("ld_to", OP_LOAD, 5'd4);
      tick(); #1 chk("ld_to_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 1,0,0, 2'd0);
      for (int i = 0; i < 5; i++) begin
         tick(); #1 chk("dmem_wait", 3'd3, 0,0,1,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      end
      tick(); #1 chk("dmem_timeout", 3'd6, 0,0,0,0,0,0, 2'd0,2'd0, 0,0,1, 2'd3);
      do_reset();

      // Reset mid-MEM drops dmem_req immediately
      fetch_decode("sw_rst", OP_STORE, 5'd0);
      tick(); #1 chk("sw_rst_exec", 3'd2, 0,0,0,0,0,0, 2'd0,2'd0, 1,0,0, 2'd0);
      tick(); #1 chk("sw_rst_mem",  3'd3, 0,0,1,1,0,0, 2'd0,2'd0, 0,0,0, 2'd0);
      #1 do_reset();
      tick(); #1 chk("post_reset_fetch", 3'd0, 1,0,0,0,0,0, 2'd0,2'd0, 0,0,0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
